updi_response_handler: RTL and testbench

- Receive-side counterpart of the UPDI instruction queue handler.
- Pops bytes from the external UART RX FIFO and discards the half-duplex echo of transmitted bytes.
- Collects response bytes (LD/LDCS data) into a buffer and checks ACK bytes (0x40) at flagged positions, pulsing ack_received to the TX-side handler.
- Ends each transaction with a done pulse carrying an error code. A timeout covers a silent target.

---
 rtl/updi_pkg.sv | 25 ++
 rtl/updi_response_handler_if.sv | 37 +++
 rtl/updi_timeout_counter.sv | 29 ++
 rtl/updi_response_handler.sv | 159 +++++++++++++++
 tb/tb_updi_response_handler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/updi_pkg.sv
// UPDI shared types and constants.
// Used by both the TX queue handler and the RX response handler.
package updi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISCARD,
    RECEIVE,
    DONE
  } updi_response_handler_state;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    TIMEOUT      = 2'd1,
    ACK_MISMATCH = 2'd2
  } updi_rsp_error;

  localparam logic [7:0] UPDI_ACK   = 8'h40;
  localparam logic [7:0] UPDI_SYNCH = 8'h55;

  function automatic logic is_updi_ack(input logic [7:0] b);
    return b == UPDI_ACK;
  endfunction

endpackage

// File: rtl/updi_response_handler_if.sv
// Bundle between the response handler, its controller and the RX FIFO.
// master = controller/FIFO side, slave = response handler.
interface updi_response_handler_if #(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE)
) ();
  import updi_pkg::*;

  logic                           start;
  logic                           ready;
  logic [DATA_ADDR_BITS:0]        discard_len;
  logic [DATA_ADDR_BITS:0]        rx_len;
  logic [MAX_DATA_SIZE-1:0]       ack_mask;
  logic                           ack_received;
  logic                           done;
  updi_rsp_error                  error;
  logic [MAX_DATA_SIZE-1:0][7:0]  rx_data;
  logic [DATA_ADDR_BITS:0]        rx_count;
  logic [7:0]                     fifo_data;
  logic                           fifo_rd_en;
  logic                           fifo_empty;

  modport master (
    output start, discard_len, rx_len, ack_mask,
    output fifo_data, fifo_empty,
    input  ready, ack_received, done, error,
    input  rx_data, rx_count, fifo_rd_en
  );

  modport slave (
    input  start, discard_len, rx_len, ack_mask,
    input  fifo_data, fifo_empty,
    output ready, ack_received, done, error,
    output rx_data, rx_count, fifo_rd_en
  );

endinterface

// File: rtl/updi_timeout_counter.sv
// Idle-cycle watchdog for the response handler.
// expired is high while enabled and the count sits at its last value.
module updi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  assign expired = enable && (timer == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && !expired) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/updi_response_handler.sv
// UPDI receive path: drops TX echo, collects response bytes, checks ACKs.
// One FIFO read in flight at most; a read already issued always lands before DONE.
module updi_response_handler
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 16,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic                    clk,
  input logic                    rst,
  updi_response_handler_if.slave bus
);
  localparam int LW = DATA_ADDR_BITS + 1;
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DATA_SIZE);

  updi_response_handler_state state;

  logic                      pending;
  logic [LW-1:0]             disc_len_q;
  logic [LW-1:0]             rx_len_q;
  logic [LW-1:0]             disc_cnt;
  logic [LW-1:0]             issued;
  logic [MAX_DATA_SIZE-1:0]  ack_mask_q;

  logic                      accept;
  logic                      active;
  logic                      consume;
  logic                      is_ack;
  logic                      chk;
  logic                      disc_last;
  logic                      rx_last;
  logic                      mismatch;
  logic                      phase_end;
  logic                      issue;
  logic                      expired;
  logic                      timeout;
  logic [LW-1:0]             phase_len;
  logic [DATA_ADDR_BITS-1:0] k;

  always_comb begin
    accept    = (state == IDLE) && bus.start && bus.ready;
    active    = (state == DISCARD) || (state == RECEIVE);
    consume   = active && pending;
    k         = bus.rx_count[DATA_ADDR_BITS-1:0];
    is_ack    = is_updi_ack(bus.fifo_data);
    chk       = ack_mask_q[k];
    phase_len = (state == DISCARD) ? disc_len_q : rx_len_q;
    disc_last = (state == DISCARD) && consume
              && (disc_cnt + ONE == disc_len_q);
    rx_last   = (state == RECEIVE) && consume
              && (bus.rx_count + ONE == rx_len_q);
    mismatch  = (state == RECEIVE) && consume && chk && !is_ack;
    phase_end = disc_last || rx_last || mismatch;
    // No new read on a phase boundary, so nothing is left in flight.
    issue     = active && !phase_end && !bus.fifo_rd_en
              && !bus.fifo_empty && (issued < phase_len);
    timeout   = expired && !consume && !issue;
  end

  updi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (active),
    .clear  (accept || issue || consume),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.ready        <= 1'b0;
      bus.done         <= 1'b0;
      bus.ack_received <= 1'b0;
      bus.error        <= NONE;
      bus.rx_count     <= '0;
      bus.rx_data      <= '0;
      bus.fifo_rd_en   <= 1'b0;
      pending          <= 1'b0;
      disc_len_q       <= '0;
      rx_len_q         <= '0;
      disc_cnt         <= '0;
      issued           <= '0;
      ack_mask_q       <= '0;
    end else begin
      bus.done         <= 1'b0;
      bus.ack_received <= 1'b0;
      bus.fifo_rd_en   <= issue;
      pending          <= bus.fifo_rd_en;
      if (issue) issued <= issued + ONE;
      unique case (state)
        IDLE: begin
          bus.ready <= 1'b1;
          if (accept) begin
            bus.ready    <= 1'b0;
            bus.rx_count <= '0;
            bus.error    <= NONE;
            disc_cnt     <= '0;
            issued       <= '0;
            disc_len_q   <= bus.discard_len;
            rx_len_q     <= (bus.rx_len > MAX_LEN) ? MAX_LEN : bus.rx_len;
            ack_mask_q   <= bus.ack_mask;
            if (bus.discard_len != '0) begin
              state <= DISCARD;
            end else if (bus.rx_len != '0) begin
              state <= RECEIVE;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        DISCARD: begin
          if (consume) disc_cnt <= disc_cnt + ONE;
          if (disc_last) begin
            issued <= '0;
            if (rx_len_q == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state <= RECEIVE;
            end
          end else if (timeout) begin
            bus.error <= TIMEOUT;
            state     <= DONE;
            bus.done  <= 1'b1;
          end
        end
        RECEIVE: begin
          if (consume) begin
            bus.rx_data[k]   <= bus.fifo_data;
            bus.rx_count     <= bus.rx_count + ONE;
            bus.ack_received <= chk && is_ack;
          end
          if (mismatch) begin
            bus.error <= ACK_MISMATCH;
            state     <= DONE;
            bus.done  <= 1'b1;
          end else if (rx_last) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (timeout) begin
            bus.error <= TIMEOUT;
            state     <= DONE;
            bus.done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updi_response_handler.sv
// Randomized bench for updi_response_handler against a byte-stream model.
// FIFO model returns data the cycle after a pop strobe.
module tb_updi_response_handler;
  import updi_pkg::*;

  localparam int MDS = 16;
  localparam int LW  = 5;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updi_response_handler_if #(.MAX_DATA_SIZE(MDS)) bus ();

  updi_response_handler #(
    .MAX_DATA_SIZE (MDS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] fq[$];
  logic [7:0] mem[MDS];
  int n_chk  = 0;
  int n_fail = 0;
  int n_ack  = 0;
  int n_pop  = 0;
  int n_done = 0;
  int last_lat;

  always @(posedge clk)
    if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_data <= fq.pop_front();

  always @(negedge clk) begin
    bus.fifo_empty <= (fq.size() == 0);
    if (bus.ack_received) n_ack++;
    if (bus.fifo_rd_en) n_pop++;
    if (bus.done) n_done++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outcome from the byte stream present when the start is taken.
  task automatic model(input logic [7:0] q[$], input int disc, input int rxl,
                       input logic [15:0] mask, output int e_pop,
                       output int e_err, output int e_cnt, output int e_ack);
    int avail, p, len;
    avail = q.size();
    len = (rxl > MDS) ? MDS : rxl;
    e_err = 0; e_cnt = 0; e_ack = 0;
    if (avail < disc) begin
      e_pop = avail; e_err = 1;
      return;
    end
    p = disc;
    for (int k = 0; k < len; k++) begin
      if (p >= avail) begin e_err = 1; break; end
      mem[k] = q[p];
      p++; e_cnt++;
      if (mask[k]) begin
        if (q[p-1] == 8'h40) e_ack++;
        else begin e_err = 2; break; end
      end
    end
    e_pop = p;
  endtask

  task automatic run_txn(input int disc, input int rxl, input logic [15:0] mask,
                         input int late_at, input logic [7:0] late_b,
                         input bit poke);
    logic [7:0] snap[$];
    int ep, ee, ec, ea, a0, p0, d0, cyc, left0;
    snap = fq;
    if (late_at >= 0) snap.push_back(late_b);
    model(snap, disc, rxl, mask, ep, ee, ec, ea);
    left0 = snap.size();
    check("ready_pre", bus.ready, 1);
    a0 = n_ack; p0 = n_pop; d0 = n_done;
    bus.start = 1'b1;
    bus.discard_len = LW'(disc);
    bus.rx_len = LW'(rxl);
    bus.ack_mask = mask;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.discard_len = LW'($urandom_range(31));
    bus.rx_len = LW'($urandom_range(31));
    bus.ack_mask = 16'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      if (cyc == late_at) fq.push_back(late_b);
      @(posedge clk); #1;
      cyc++;
    end
    last_lat = cyc;
    check("done_seen", bus.done, 1);
    check("error", bus.error, ee);
    check("rx_count", bus.rx_count, ec);
    for (int i = 0; i < MDS; i++)
      check($sformatf("rx_data%0d", i), bus.rx_data[i], mem[i]);
    if (poke) begin
      bus.start = 1'b1;
      bus.discard_len = '0;
      bus.rx_len = '0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("done_width", bus.done, 0);
    check("ready_post", bus.ready, 1);
    check("ack_pulses", n_ack - a0, ea);
    check("pops", n_pop - p0, ep);
    check("done_pulses", n_done - d0, 1);
    check("fifo_left", fq.size(), left0 - ep);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int disc, rxl, n, d0, cyc;
    logic [15:0] mask;
    logic [7:0] b;
    foreach (mem[i]) mem[i] = 8'h00;
    bus.start = 1'b0;
    bus.discard_len = '0;
    bus.rx_len = '0;
    bus.ack_mask = '0;
    #2;
    check("rst_ready", bus.ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_count", bus.rx_count, 0);
    check("rst_rden", bus.fifo_rd_en, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_in_first", bus.ready, 0);
    @(posedge clk); #1;
    check("ready_after", bus.ready, 1);

    fq = '{8'h55, 8'h80, 8'h1E};
    @(posedge clk); #1;
    run_txn(2, 1, 16'h0, -1, 8'h00, 1'b0);

    fq = '{8'h40, 8'h40};
    @(posedge clk); #1;
    run_txn(0, 2, 16'h3, -1, 8'h00, 1'b0);

    fq = '{8'h41, 8'h40};
    @(posedge clk); #1;
    run_txn(0, 2, 16'h1, -1, 8'h00, 1'b0);

    fq.delete();
    @(posedge clk); #1;
    run_txn(0, 1, 16'h0, -1, 8'h00, 1'b0);
    check("timeout_lat", int'(last_lat <= 17), 1);

    run_txn(0, 1, 16'h0, 15, 8'hA7, 1'b0);

    run_txn(0, 0, 16'h0, -1, 8'h00, 1'b1);
    check("zero_lat", last_lat, 1);
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_ign", n_done - d0, 0);
    check("ready_idle", bus.ready, 1);

    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(posedge clk); #1;
    d0 = n_done;
    bus.start = 1'b1;
    bus.discard_len = '0;
    bus.rx_len = LW'(4);
    bus.ack_mask = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.rx_count != 1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_count", bus.rx_count, 1);
    rst = 1'b1;
    #1;
    check("mid_ready", bus.ready, 0);
    check("mid_count_rst", bus.rx_count, 0);
    check("mid_rden", bus.fifo_rd_en, 0);
    check("mid_data", int'(bus.rx_data != '0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    fq.delete();
    foreach (mem[i]) mem[i] = 8'h00;
    @(posedge clk); #1;
    check("mid_no_done", n_done - d0, 0);
    fq = '{8'h40, 8'h5A};
    @(posedge clk); #1;
    run_txn(0, 2, 16'h1, -1, 8'h00, 1'b0);

    repeat (30) begin
      disc = $urandom_range(0, 4);
      rxl = $urandom_range(0, 18);
      mask = 16'($urandom & $urandom);
      n = disc + rxl;
      if ($urandom_range(0, 5) == 0) n = $urandom_range(0, n);
      else n = n + 2;
      fq.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (i >= disc && i - disc < MDS && $urandom_range(0, 7) != 0)
          if (mask[i-disc]) b = 8'h40;
        fq.push_back(b);
      end
      @(posedge clk); #1;
      run_txn(disc, rxl, mask, -1, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
